// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, IDLE/REQ/WAIT memory fetch FSM and instruction register.
// Optional build macro FETCH_TIMEOUT_EN abandons a fetch after TIMEOUT_CYC silent WAIT cycles.
module fetch_unit #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        pc_rst,
   input  logic        pc_write,
   input  logic        pc_sel,
   input  logic        br_sel,
   input  logic        ir_load,
   input  logic [15:0] imm,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [31:0] ir,
   output logic [15:0] pc_out,
   output logic        fetch_busy,
   output logic        fetch_done,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t      state, state_nx;
   logic [15:0] pc, pc_nx;
   logic        discard, discard_nx;
   logic        start, accept, drop, timeout;

   generate
      if (TIMEOUT_CYC < 1) begin : g_bad_timeout
         $error("fetch_unit: TIMEOUT_CYC must be at least 1");
      end
   endgenerate

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      pc_nx = pc;
      if (pc_rst)
         pc_nx = '0;
      else if (pc_write) begin
         if (!pc_sel)
            pc_nx = pc + 16'd1;
         else if (br_sel)
            pc_nx = imm;
         else
            pc_nx = pc + imm;  // 16-bit add of the raw offset is the sign-extended sum mod 2^16
      end
   end

   // A response arriving while the discard flag is set belongs to an abandoned fetch.
   always_comb begin
      start   = (state == IDLE) && ir_load && !pc_rst;
      drop    = mem_rvalid && discard;
      accept  = (state != IDLE) && mem_rvalid && !discard && !pc_rst;
   end

   always_comb begin
      state_nx   = state;
      mem_req    = 1'b0;
      fetch_busy = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               state_nx = REQ;
         end
         REQ, WAIT: begin
            fetch_busy = 1'b1;
            mem_req    = (state == REQ);
            if (pc_rst || accept || timeout)
               state_nx = IDLE;
            else if (state == REQ)
               state_nx = WAIT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // An abort leaves a response outstanding unless this very cycle delivered it.
   always_comb begin
      discard_nx = discard;
      if (drop)
         discard_nx = 1'b0;
      if ((state != IDLE) && pc_rst && !(mem_rvalid && !discard))
         discard_nx = 1'b1;
      if (timeout)
         discard_nx = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state      <= IDLE;
         pc         <= '0;
         discard    <= 1'b0;
         mem_addr   <= '0;
         ir         <= '0;
         fetch_done <= 1'b0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         discard    <= discard_nx;
         fetch_done <= accept;
         if (start)
            mem_addr <= pc;
         if (accept)
            ir <= mem_rdata;
      end
   end

   assign pc_out = pc;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] tmo_cnt;

   assign timeout = (state == WAIT) && !accept && !pc_rst &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         tmo_cnt   <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (start)
            tmo_cnt <= '0;
         else if (state == WAIT)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         if (pc_rst)
            fetch_err <= 1'b0;
         else if (timeout)
            fetch_err <= 1'b1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected IR words popped on fetch_done.
// Build with FETCH_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYC=4).
module tb_fetch_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_f = 1'b1;
   logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, mem_rvalid;
   logic [15:0] imm;
   logic [31:0] mem_rdata;
   logic        mem_req, fetch_busy, fetch_done, fetch_err;
   logic [15:0] mem_addr, pc_out;
   logic [31:0] ir;

   int          n_checks = 0;
   int          n_errors = 0;
   int          req_count = 0;
   int          done_count = 0;
   int          r0, d0;
   logic [31:0] exp_q[$];

   fetch_unit #(.TIMEOUT_CYC(TMO)) dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .pc_rst    (pc_rst),
      .pc_write  (pc_write),
      .pc_sel    (pc_sel),
      .br_sel    (br_sel),
      .ir_load   (ir_load),
      .imm       (imm),
      .mem_rdata (mem_rdata),
      .mem_rvalid(mem_rvalid),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .ir        (ir),
      .pc_out    (pc_out),
      .fetch_busy(fetch_busy),
      .fetch_done(fetch_done),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every fetch_done must match the oldest expected instruction word.
   always @(negedge clk) begin
      if (rst_f === 1'b1) begin
         if (mem_req === 1'b1)
            req_count++;
         if (fetch_done === 1'b1) begin
            done_count++;
            if (exp_q.size() == 0)
               check("unexpected_done_sb_size", 32'(exp_q.size()), 32'd1);
            else
               check("ir_on_done", ir, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [15:0] v);
      pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1; imm = v;
      tick();
      pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0; imm = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pc"}, 32'(pc_out), 32'd0);
      check({tag, "_ir"}, ir, 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_req"}, 32'(mem_req), 32'd0);
      check({tag, "_busy"}, 32'(fetch_busy), 32'd0);
      check({tag, "_done"}, 32'(fetch_done), 32'd0);
      check({tag, "_err"}, 32'(fetch_err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
      imm = '0; mem_rdata = '0; mem_rvalid = 0;
      #1 rst_f = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk) rst_f = 1'b1;
      tick();

      // PC arithmetic
      set_pc(16'hFFFF);
      check("pc_abs_ffff", 32'(pc_out), 32'h0000_FFFF);
      pc_write = 1; pc_sel = 0; tick(); pc_write = 0;
      check("pc_wrap", 32'(pc_out), 32'h0000_0000);
      set_pc(16'h0020);
      pc_write = 1; pc_sel = 1; br_sel = 0; imm = 16'hFFF0; tick();
      check("pc_rel_neg", 32'(pc_out), 32'h0000_0010);
      br_sel = 1; imm = 16'h1234; tick();
      check("pc_abs", 32'(pc_out), 32'h0000_1234);
      br_sel = 0; imm = 16'h0005; tick();
      check("pc_rel_pos", 32'(pc_out), 32'h0000_1239);
      pc_write = 0; pc_sel = 0; imm = '0;

      // Basic fetch, response three cycles after the request cycle
      set_pc(16'h0010);
      r0 = req_count; d0 = done_count;
      ir_load = 1; tick(); ir_load = 0;
      check("f1_req", 32'(mem_req), 32'd1);
      check("f1_busy", 32'(fetch_busy), 32'd1);
      check("f1_addr", 32'(mem_addr), 32'h0000_0010);
      tick();
      check("f1_req_one_cycle", 32'(mem_req), 32'd0);
      tick();
      tick();
      mem_rvalid = 1; mem_rdata = 32'h8123_0000; exp_q.push_back(32'h8123_0000);
      check("f1_done_early", 32'(fetch_done), 32'd0);
      tick();
      mem_rvalid = 0; mem_rdata = '0;
      check("f1_ir", ir, 32'h8123_0000);
      check("f1_done", 32'(fetch_done), 32'd1);
      check("f1_busy_drop", 32'(fetch_busy), 32'd0);
      tick();
      check("f1_done_pulse", 32'(fetch_done), 32'd0);
      check("f1_req_count", 32'(req_count - r0), 32'd1);
      check("f1_done_count", 32'(done_count - d0), 32'd1);

      // ir_load while busy, pc_write during fetch, rvalid while idle
      set_pc(16'h0040);
      r0 = req_count; d0 = done_count;
      ir_load = 1; tick();
      tick();
      pc_write = 1; tick(); pc_write = 0;
      check("f2_pc_during_fetch", 32'(pc_out), 32'h0000_0041);
      check("f2_addr_held", 32'(mem_addr), 32'h0000_0040);
      tick();
      tick();
      ir_load = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001; exp_q.push_back(32'hCAFE_0001);
      tick();
      mem_rdata = 32'hDEAD_BEEF;
      check("f2_ir", ir, 32'hCAFE_0001);
      tick();
      mem_rvalid = 0; mem_rdata = '0;
      check("f2_idle_rvalid_ir", ir, 32'hCAFE_0001);
      check("f2_idle_rvalid_busy", 32'(fetch_busy), 32'd0);
      tick();
      check("f2_req_count", 32'(req_count - r0), 32'd1);
      check("f2_done_count", 32'(done_count - d0), 32'd1);

      // Abort in WAIT, then the new fetch takes the second response
      set_pc(16'h0077);
      ir_load = 1; tick(); ir_load = 0;
      tick();
      pc_rst = 1; tick(); pc_rst = 0;
      check("ab_busy", 32'(fetch_busy), 32'd0);
      check("ab_pc", 32'(pc_out), 32'd0);
      check("ab_ir", ir, 32'hCAFE_0001);
      d0 = done_count;
      ir_load = 1; tick(); ir_load = 0;
      tick();
      mem_rvalid = 1; mem_rdata = 32'hAAAA_0000; tick();
      check("ab_drop_ir", ir, 32'hCAFE_0001);
      check("ab_drop_busy", 32'(fetch_busy), 32'd1);
      mem_rdata = 32'h5555_0000; exp_q.push_back(32'h5555_0000); tick();
      mem_rvalid = 0; mem_rdata = '0;
      check("ab_ir", ir, 32'h5555_0000);
      check("ab_pc_final", 32'(pc_out), 32'd0);
      tick();
      check("ab_done_count", 32'(done_count - d0), 32'd1);

      // pc_rst and ir_load together in IDLE
      set_pc(16'h0033);
      r0 = req_count;
      pc_rst = 1; ir_load = 1; tick(); pc_rst = 0; ir_load = 0;
      check("rl_pc", 32'(pc_out), 32'd0);
      check("rl_busy", 32'(fetch_busy), 32'd0);
      tick();
      check("rl_req_count", 32'(req_count - r0), 32'd0);

`ifdef FETCH_TIMEOUT_EN
      ir_load = 1; tick(); ir_load = 0;
      tick();
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         check("to_err_early", 32'(fetch_err), 32'd0);
         check("to_busy_early", 32'(fetch_busy), 32'd1);
      end
      tick();
      check("to_err", 32'(fetch_err), 32'd1);
      check("to_busy", 32'(fetch_busy), 32'd0);
      mem_rvalid = 1; mem_rdata = 32'hBEEF_0000; tick();
      mem_rvalid = 0; mem_rdata = '0;
      check("to_late_ir", ir, 32'h5555_0000);
      check("to_err_sticky", 32'(fetch_err), 32'd1);
      pc_rst = 1; tick(); pc_rst = 0;
      check("to_err_clear", 32'(fetch_err), 32'd0);
`else
      ir_load = 1; tick(); ir_load = 0;
      for (int i = 0; i < 20; i++)
         tick();
      check("nt_busy", 32'(fetch_busy), 32'd1);
      check("nt_err", 32'(fetch_err), 32'd0);
      mem_rvalid = 1; mem_rdata = 32'h2468_0000; exp_q.push_back(32'h2468_0000); tick();
      mem_rvalid = 0; mem_rdata = '0;
      check("nt_ir", ir, 32'h2468_0000);
`endif
      tick();

      // Asynchronous reset in the middle of a fetch
      set_pc(16'h0099);
      ir_load = 1; tick(); ir_load = 0;
      tick();
      #2 rst_f = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk) rst_f = 1'b1;
      tick();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, is the maximum number of WAIT cycles without mem_rvalid before the fetch is abandoned (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  system clock, rising edge active.
REQ-003 rst_f  input  1  reset, asynchronous, active-low.
REQ-004 pc_rst  input  1  synchronous PC clear from the control unit.
REQ-005 pc_write  input  1  PC update enable.
REQ-006 pc_sel  input  1  0 = PC+1, 1 = branch target.
REQ-007 br_sel  input  1  1 = absolute branch, 0 = relative branch.
REQ-008 ir_load  input  1  fetch request: start a memory read at the current PC.
REQ-009 imm  input  16  branch address or two's-complement offset.
REQ-010 mem_rdata  input  32  instruction word returned by memory.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 mem_req  output  1  one-cycle read request strobe.
REQ-013 mem_addr  output  16  read address, registered.
REQ-014 ir  output  32  instruction register.
REQ-015 pc_out  output  16  current PC.
REQ-016 fetch_busy  output  1  fetch in progress.
REQ-017 fetch_done  output  1  one-cycle pulse when the IR is loaded.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 When pc_write=1 and pc_sel=0, PC SHALL become PC+1 modulo 2^16 on the next clock edge, so 0xFFFF wraps to 0x0000.
REQ-020 When pc_write=1, pc_sel=1 and br_sel=1, PC SHALL become imm on the next clock edge.
REQ-021 When pc_write=1, pc_sel=1 and br_sel=0, PC SHALL become PC+imm, with imm sign-extended and the sum taken modulo 2^16.
REQ-022 pc_rst=1 SHALL clear PC to 0 on the next edge, taking priority over pc_write.
REQ-023 The fetch FSM SHALL have states IDLE, REQ and WAIT.
REQ-024 In IDLE, ir_load=1 SHALL latch PC into mem_addr and move the FSM to REQ.
REQ-025 In REQ, mem_req SHALL be 1 for exactly one cycle, after which the FSM moves to WAIT.
REQ-026 In REQ or WAIT, mem_rvalid=1 SHALL load mem_rdata into ir, pulse fetch_done for one cycle and return the FSM to IDLE; this makes the minimum latency 2 cycles from ir_load to fetch_done.
REQ-027 fetch_busy SHALL be 1 in REQ and WAIT and 0 in IDLE.
REQ-028 ir_load while busy SHALL be ignored.
REQ-029 mem_rvalid in IDLE SHALL be ignored.
REQ-030 pc_write during a fetch SHALL update PC without changing mem_addr.
REQ-031 pc_rst in REQ or WAIT SHALL abort the fetch: the FSM returns to IDLE, ir is unchanged, and a discard flag is set.
REQ-032 The next mem_rvalid after the discard flag is set SHALL be dropped, and dropping it SHALL clear the flag.
REQ-033 A new fetch SHALL be allowed while the discard flag is set, and its response is the second rvalid.
REQ-034 pc_rst and ir_load in the same IDLE cycle SHALL clear PC and start no fetch.
REQ-035 ir SHALL change only on an accepted rvalid.

Reset
REQ-036 rst_f low SHALL immediately set PC=0, ir=0, mem_addr=0, mem_req=0, fetch_done=0, fetch_busy=0, fetch_err=0, clear the discard flag and put the FSM in IDLE.
REQ-037 Operation SHALL resume on the first rising clk edge after rst_f goes high.

Configuration
REQ-038 With FETCH_TIMEOUT_EN defined, a counter SHALL run while the FSM is in WAIT and clear on entering REQ.
REQ-039 With FETCH_TIMEOUT_EN defined, TIMEOUT_CYC WAIT cycles without rvalid SHALL set fetch_err, return the FSM to IDLE and set the discard flag.
REQ-040 With FETCH_TIMEOUT_EN defined, fetch_err SHALL stay set until pc_rst or rst_f.
REQ-041 Without FETCH_TIMEOUT_EN, fetch_err SHALL be constant 0 and WAIT SHALL last until rvalid arrives.

Verification
REQ-042 PC=0x0010, ir_load, rvalid 3 cycles after the request with data 0x81230000 -> mem_addr=0x0010, one mem_req pulse, ir=0x81230000, one fetch_done pulse, fetch_busy drops the same cycle.
REQ-043 PC=0xFFFF, pc_write, pc_sel=0 -> PC=0x0000; PC=0x0020, pc_sel=1, br_sel=0, imm=0xFFF0 -> PC=0x0010; br_sel=1, imm=0x1234 -> PC=0x1234.
REQ-044 pc_rst during WAIT, then a new ir_load, then two rvalids with 0xAAAA0000 and 0x55550000 -> first rvalid dropped, ir=0x55550000, PC=0, exactly one fetch_done.
REQ-045 ir_load repeated while busy, and rvalid while IDLE -> no extra mem_req, ir unchanged.
REQ-046 FETCH_TIMEOUT_EN with TIMEOUT_CYC=4 and no rvalid -> fetch_err=1 after 4 WAIT cycles, FSM in IDLE, a late rvalid dropped, fetch_err cleared by pc_rst.
REQ-047 rst_f asserted mid-fetch, asynchronously between clock edges -> all outputs zero immediately.
